// File: rtl/mux_sel_sequencer.sv
// mux_sel_sequencer: drives an 8:1 mux with a captured word, scans sel 0..7 and reassembles the sampled bits.
// Define MUX_SEQ_PARITY_EN to add a running XOR parity output over the sampled bits.
module mux_sel_sequencer #(
  parameter int NUM_INPUTS  = 8,
  parameter int SEL_W       = 3,
  parameter int HOLD_CYCLES = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  abort,
  input  logic [NUM_INPUTS-1:0] data_in,
  input  logic                  mux_out,
  output logic [NUM_INPUTS-1:0] mux_in,
  output logic [SEL_W-1:0]      sel,
  output logic                  ready,
  output logic                  busy,
  output logic                  ser_out,
  output logic                  ser_valid,
  output logic [NUM_INPUTS-1:0] rx_word,
  output logic                  done,
  output logic                  match
`ifdef MUX_SEQ_PARITY_EN
  ,
  output logic                  parity
`endif
);
  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;
  state_t state_q, state_d;
  logic [NUM_INPUTS-1:0] mux_in_q, mux_in_d, rx_q, rx_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic [3:0] cnt_q, cnt_d;
  logic ser_out_q, ser_out_d, ser_valid_q, ser_valid_d, done_q, done_d, match_q, match_d;
  logic par_q, par_d;
  logic last_slot;
  assign last_slot = cnt_q == 4'(HOLD_CYCLES - 1);
  always_comb begin
    state_d     = state_q;
    mux_in_d    = mux_in_q;
    rx_d        = rx_q;
    sel_d       = sel_q;
    cnt_d       = cnt_q;
    ser_out_d   = ser_out_q;
    ser_valid_d = 1'b0;
    done_d      = 1'b0;
    match_d     = 1'b0;
    par_d       = par_q;
    case (state_q)
      IDLE: if (start && !abort) begin
        state_d  = SCAN;
        mux_in_d = data_in;
        rx_d     = '0;
        sel_d    = '0;
        cnt_d    = '0;
        par_d    = 1'b0;
      end
      SCAN: if (abort) begin
        // abort wins over a coinciding sample: nothing is recorded on this edge
        state_d = IDLE;
        sel_d   = '0;
        cnt_d   = '0;
      end else if (last_slot) begin
        cnt_d       = '0;
        ser_out_d   = mux_out;
        rx_d[sel_q] = mux_out;
        ser_valid_d = 1'b1;
        par_d       = par_q ^ mux_out;
        if (sel_q == SEL_W'(NUM_INPUTS - 1)) begin
          state_d = DONE;
          done_d  = 1'b1;
          match_d = rx_d == mux_in_q;
        end else sel_d = sel_q + 1'b1;
      end else cnt_d = cnt_q + 4'd1;
      DONE: begin
        state_d = IDLE;
        sel_d   = '0;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q     <= IDLE;
      mux_in_q    <= '0;
      rx_q        <= '0;
      sel_q       <= '0;
      cnt_q       <= '0;
      ser_out_q   <= 1'b0;
      ser_valid_q <= 1'b0;
      done_q      <= 1'b0;
      match_q     <= 1'b0;
      par_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      mux_in_q    <= mux_in_d;
      rx_q        <= rx_d;
      sel_q       <= sel_d;
      cnt_q       <= cnt_d;
      ser_out_q   <= ser_out_d;
      ser_valid_q <= ser_valid_d;
      done_q      <= done_d;
      match_q     <= match_d;
      par_q       <= par_d;
    end
  assign mux_in    = mux_in_q;
  assign sel       = sel_q;
  assign ready     = state_q == IDLE;
  assign busy      = state_q == SCAN;
  assign ser_out   = ser_out_q;
  assign ser_valid = ser_valid_q;
  assign rx_word   = rx_q;
  assign done      = done_q;
  assign match     = match_q;
`ifdef MUX_SEQ_PARITY_EN
  assign parity = par_q;
`else
  logic unused_par;
  assign unused_par = par_q;
`endif
endmodule
